// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector family.
package seq_det_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam logic [7:0]  DEF_PATTERN = 8'h05;
  localparam int unsigned DEF_LEN     = 3;

  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len) + 1;
  endfunction

  // Lengths outside 1..max_len are pulled to the nearest legal value.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised saturating counter; clr together with inc restarts the count at 1.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = W'(inc_i);
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable Mealy serial pattern detector with overlap control and match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = DEF_MAX_LEN,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int unsigned        RST_LEN     = DEF_LEN,
  parameter bit                 RST_OVERLAP = 1'b1,
  localparam int unsigned       LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               x_valid,
  input  logic               x,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  localparam logic [LEN_W-1:0] FillMax  = LEN_W'(MAX_LEN - 1);
  localparam logic [LEN_W-1:0] RstLenQ  = LEN_W'(clamp_len(RST_LEN, MAX_LEN));

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;

  assign window = {hist_q, x};
  assign armed  = (fill_q >= (len_q - LEN_W'(1)));

  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign z = x_valid & ~cfg_load & armed & (((window ^ pattern_q) & len_mask) == '0);

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
      ovl_d     = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (x_valid) begin
      hist_d = window[MAX_LEN-2:0];
      // Non-overlap restart: zeroing fill makes the stale history unusable.
      if (z && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= RST_PATTERN;
      len_q     <= RstLenQ;
      ovl_q     <= RST_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk_i(clk),
    .rst_i(reset),
    .clr_i(cnt_clr),
    .inc_i(z),
    .cnt_o(match_cnt)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Randomised and directed bench for seq_pattern_detector against a queue-based reference model.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       x_valid;
  logic       x;
  logic       cnt_clr;
  logic       z_a, z_b, armed_a, armed_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int errors = 0;
  int checks = 0;

  // Reference model: bits received since the last (re)start, oldest first.
  bit         hist_m[$];
  int         len_m;
  logic [7:0] pat_m;
  bit         ovl_m;
  int         cnt_a_m, cnt_b_m;

  always #5 clk = ~clk;

  seq_pattern_detector dut_a (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
    .cnt_clr(cnt_clr), .z(z_a), .match_cnt(cnt_a), .armed(armed_a)
  );

  seq_pattern_detector #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
    .cnt_clr(cnt_clr), .z(z_b), .match_cnt(cnt_b), .armed(armed_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic bit model_armed();
    return hist_m.size() >= len_m - 1;
  endfunction

  function automatic bit model_z(input bit v, input bit xb, input bit ld);
    int n;
    bit b;
    if (!v || ld || !model_armed()) return 1'b0;
    n = hist_m.size();
    for (int i = 0; i < len_m; i++) begin
      b = (i == 0) ? xb : hist_m[n - i];
      if (b != pat_m[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist_m.delete();
    pat_m   = 8'h05;
    len_m   = 3;
    ovl_m   = 1'b1;
    cnt_a_m = 0;
    cnt_b_m = 0;
  endtask

  task automatic model_edge(input bit zm);
    if (cnt_clr) begin
      cnt_a_m = zm ? 1 : 0;
      cnt_b_m = zm ? 1 : 0;
    end else if (zm) begin
      if (cnt_a_m < 255) cnt_a_m++;
      if (cnt_b_m < 3) cnt_b_m++;
    end
    if (cfg_load) begin
      pat_m = cfg_pattern;
      len_m = (cfg_len == 0) ? 1 : (cfg_len > 8) ? 8 : int'(cfg_len);
      ovl_m = cfg_overlap;
      hist_m.delete();
    end else if (x_valid) begin
      if (zm && !ovl_m) begin
        hist_m.delete();
      end else begin
        hist_m.push_back(x);
        if (hist_m.size() > 7) void'(hist_m.pop_front());
      end
    end
  endtask

  // Called just after a falling edge; checks outputs, then advances one clock.
  task automatic step(input bit v, input bit xb, input bit ld, input bit clr);
    bit zm;
    x_valid  = v;
    x        = xb;
    cfg_load = ld;
    cnt_clr  = clr;
    #1;
    zm = model_z(v, xb, ld);
    check("z", z_a, zm);
    check("z_cnt2", z_b, zm);
    check("armed", armed_a, model_armed());
    check("cnt8", cnt_a, cnt_a_m);
    check("cnt2", cnt_b, cnt_b_m);
    @(posedge clk);
    model_edge(zm);
    @(negedge clk);
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o, input bit clr);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    step(1'b1, 1'b1, 1'b1, clr);
  endtask

  task automatic stream(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_armed", armed_a, 1'b0);
    check("rst_cnt", cnt_a, 0);
    check("rst_z", z_a, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    x_valid = 1'b0; x = 1'b0; cnt_clr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_armed", armed_a, 1'b0);
    check("reset_cnt", cnt_a, 0);
    reset = 1'b0;

    // Default "101" overlapping.
    stream(16'b10101, 5);
    check("tp1_cnt", cnt_a, 2);

    // 1011 non-overlap, then overlap.
    load(8'b1011, 4'd4, 1'b0, 1'b1);
    stream(16'b1011011, 7);
    check("tp2_cnt", cnt_a, 1);
    load(8'b1011, 4'd4, 1'b1, 1'b1);
    stream(16'b1011011, 7);
    check("tp3_cnt", cnt_a, 2);

    // Valid gap keeps history.
    load(8'b101, 4'd3, 1'b1, 1'b1);
    stream(16'b10, 2);
    for (int i = 0; i < 5; i++) step(1'b0, i[0], 1'b0, 1'b0);
    stream(16'b1, 1);
    check("gap_cnt", cnt_a, 1);

    // Saturation, clear-with-match, clear alone.
    load(8'b101, 4'd3, 1'b1, 1'b1);
    stream(16'b10101010101, 11);
    check("sat_cnt2", cnt_b, 3);
    check("sat_cnt8", cnt_a, 5);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_match", cnt_a, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_only", cnt_a, 0);

    // Length clamps.
    load(8'h01, 4'd0, 1'b0, 1'b1);
    stream(16'b1101, 4);
    check("len0_cnt", cnt_a, 3);
    load(8'hA5, 4'd15, 1'b1, 1'b1);
    stream(16'b1010_0101, 8);
    check("len15_cnt", cnt_a, 1);

    // Reset mid-pattern restores defaults.
    stream(16'b10, 2);
    pulse_reset();
    stream(16'b101, 3);
    check("post_rst_cnt", cnt_a, 1);

    // Random traffic with occasional reconfiguration and clears.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        load(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, 1'($urandom_range(0, 29) == 0));
      end
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
